// File: rtl/rob_recovery_ctrl_pkg.sv
// rob_recovery_ctrl_pkg: shared constants, recovery state enum and ROB/PRN index types
package rob_recovery_ctrl_pkg;
    localparam int WAYS = 2;
    localparam int ROB  = 32;
    localparam int PRF  = 64;
    localparam int XLEN = 32;
    localparam int IW   = $clog2(ROB);
    localparam int PW   = $clog2(PRF);
    typedef logic [IW-1:0] rob_idx_t;
    typedef logic [PW-1:0] prn_t;
    typedef enum logic [2:0] {IDLE, FLUSH, WALK, RESTORE, REDIRECT} recovery_state_t;
endpackage

// File: rtl/rob_walk_lane_gen.sv
// rob_walk_lane_gen: per-cycle walk lanes, youngest-first below ptr, up to WAYS entries
module rob_walk_lane_gen
    import rob_recovery_ctrl_pkg::*;
(
    input  logic               en,
    input  logic [IW-1:0]      ptr,
    input  logic [IW:0]        remaining,
    output logic [WAYS*IW-1:0] walk_idx,
    output logic [WAYS-1:0]    walk_rd_en,
    output logic [IW:0]        n
);
    // Entries taken this cycle: min(WAYS, remaining) while walking
    always_comb n = !en ? '0 : (remaining < (IW+1)'(WAYS)) ? remaining : (IW+1)'(WAYS);
    for (genvar i = 0; i < WAYS; i++) begin : g_lane
        assign walk_rd_en[i] = (IW+1)'(i) < n;
        assign walk_idx[i*IW +: IW] = walk_rd_en[i] ? ptr - IW'(i + 1) : '0;
    end
endmodule

// File: rtl/rob_recovery_ctrl.sv
// rob_recovery_ctrl: mispredict recovery sequencer (flush, ROB walk, RAT restore, redirect); optional stats via RECOVERY_STATS_EN
module rob_recovery_ctrl
    import rob_recovery_ctrl_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               nuke,
    input  logic [XLEN-1:0]    nuke_PC,
    input  logic [IW-1:0]      rob_tail,
    input  logic [IW:0]        squash_count,
    output logic [WAYS*IW-1:0] walk_idx,
    output logic [WAYS-1:0]    walk_rd_en,
    input  logic [WAYS*PW-1:0] walk_PRN,
    input  logic [WAYS-1:0]    walk_reg_write,
    output logic [WAYS*PW-1:0] free_PRN,
    output logic [WAYS-1:0]    free_valid,
    output logic               flush_pipe,
    output logic               stall_dispatch,
    output logic               rat_restore,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_PC,
    output logic               busy
`ifdef RECOVERY_STATS_EN
    ,
    output logic [31:0]        recovery_count,
    output logic [31:0]        recovery_cycles
`endif
);
    recovery_state_t state, state_nxt;
    logic [IW-1:0]   ptr;
    logic [IW:0]     remaining, n;
    logic [XLEN-1:0] pc;
    logic            walking, accept;

    rob_walk_lane_gen u_lanes (
        .en(walking),
        .ptr(ptr),
        .remaining(remaining),
        .walk_idx(walk_idx),
        .walk_rd_en(walk_rd_en),
        .n(n)
    );

    // State register
    always_ff @(posedge clock) state <= reset ? IDLE : state_nxt;

    // Next state: a walk ends on the cycle that consumes the last entries
    always_comb
        state_nxt = state == IDLE    ? (nuke ? FLUSH : IDLE) :
                    state == FLUSH   ? (remaining != '0 ? WALK : RESTORE) :
                    state == WALK    ? (remaining == n ? RESTORE : WALK) :
                    state == RESTORE ? REDIRECT : IDLE;

    // State-decoded strobes; freed PRNs pass straight through from the ROB read
    always_comb begin
        walking        = state == WALK;
        accept         = state == IDLE && nuke;
        flush_pipe     = state == FLUSH;
        rat_restore    = state == RESTORE;
        redirect_valid = state == REDIRECT;
        busy           = state != IDLE;
        stall_dispatch = state != IDLE;
        free_valid     = walk_rd_en & walk_reg_write;
    end
    for (genvar i = 0; i < WAYS; i++) begin : g_free
        assign free_PRN[i*PW +: PW] = walk_rd_en[i] ? walk_PRN[i*PW +: PW] : '0;
    end

    // Recovery context: latched on an accepted nuke, stepped down while walking
    always_ff @(posedge clock)
        if (reset) begin
            ptr         <= '0;
            remaining   <= '0;
            pc          <= '0;
            redirect_PC <= '0;
        end else begin
            if (accept) begin
                ptr       <= rob_tail;
                remaining <= squash_count;
                pc        <= nuke_PC;
            end
            if (walking) begin
                ptr       <= ptr - n[IW-1:0];
                remaining <= remaining - n;
            end
            if (state == RESTORE) redirect_PC <= pc;
        end

`ifdef RECOVERY_STATS_EN
    // Saturating recovery statistics
    always_ff @(posedge clock)
        if (reset) begin
            recovery_count  <= '0;
            recovery_cycles <= '0;
        end else begin
            if (accept && ~&recovery_count) recovery_count <= recovery_count + 32'd1;
            if (busy && ~&recovery_cycles) recovery_cycles <= recovery_cycles + 32'd1;
        end
`endif
endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// tb_rob_recovery_ctrl: scoreboard bench for rob_recovery_ctrl with a small ROB array model
module tb_rob_recovery_ctrl;
    import rob_recovery_ctrl_pkg::*;

    typedef struct packed {
        logic        flush, busy, rat, rv;
        logic [1:0]  rd;
        logic [9:0]  idx;
        logic [1:0]  fv;
        logic [11:0] prn;
        logic        cpc;
        logic [31:0] pc;
    } rec_t;

    logic clock, reset, nuke;
    logic [31:0] nuke_PC, redirect_PC;
    logic [4:0] rob_tail;
    logic [5:0] squash_count;
    logic [9:0] walk_idx;
    logic [1:0] walk_rd_en, walk_reg_write, free_valid;
    logic [11:0] walk_PRN, free_PRN;
    logic flush_pipe, stall_dispatch, rat_restore, redirect_valid, busy;
`ifdef RECOVERY_STATS_EN
    logic [31:0] recovery_count, recovery_cycles;
`endif

    logic [5:0] rob_prn [ROB];
    logic       rob_rw  [ROB];
    rec_t q[$];
    rec_t mon_r;
    int checks = 0, errors = 0;

    rob_recovery_ctrl dut (
        .clock(clock), .reset(reset), .nuke(nuke), .nuke_PC(nuke_PC),
        .rob_tail(rob_tail), .squash_count(squash_count),
        .walk_idx(walk_idx), .walk_rd_en(walk_rd_en),
        .walk_PRN(walk_PRN), .walk_reg_write(walk_reg_write),
        .free_PRN(free_PRN), .free_valid(free_valid),
        .flush_pipe(flush_pipe), .stall_dispatch(stall_dispatch),
        .rat_restore(rat_restore), .redirect_valid(redirect_valid),
        .redirect_PC(redirect_PC), .busy(busy)
`ifdef RECOVERY_STATS_EN
        , .recovery_count(recovery_count), .recovery_cycles(recovery_cycles)
`endif
    );

    for (genvar l = 0; l < 2; l++) begin : g_rob
        assign walk_PRN[l*6 +: 6]  = rob_prn[walk_idx[l*5 +: 5]];
        assign walk_reg_write[l]   = rob_rw[walk_idx[l*5 +: 5]];
    end

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Expected per-cycle outputs for one recovery; cut>=0 truncates for a reset
    task automatic push_model(input int tail, input int k, input logic [31:0] pc, input int cut);
        rec_t r;
        rec_t lst[$];
        int e;
        r = '0; r.flush = 1; r.busy = 1; lst.push_back(r);
        for (int j = 0; j < k; j += 2) begin
            r = '0; r.busy = 1;
            for (int l = 0; l < 2; l++)
                if (j + l < k) begin
                    e = (tail + ROB - 1 - j - l) % ROB;
                    r.rd[l] = 1'b1;
                    r.idx[l*5 +: 5] = e[4:0];
                    r.fv[l] = rob_rw[e];
                    r.prn[l*6 +: 6] = rob_prn[e];
                end
            lst.push_back(r);
        end
        r = '0; r.busy = 1; r.rat = 1; lst.push_back(r);
        r = '0; r.busy = 1; r.rv = 1; r.cpc = 1; r.pc = pc; lst.push_back(r);
        r = '0; r.cpc = 1; r.pc = pc; lst.push_back(r);
        if (cut >= 0) begin
            for (int i = 0; i < cut; i++) q.push_back(lst[i]);
            r = '0; r.cpc = 1; q.push_back(r);
        end else
            foreach (lst[i]) q.push_back(lst[i]);
    endtask

    task automatic run(input int tail, input int k, input logic [31:0] pc, input int intr, input int rst_at);
        @(negedge clock);
        push_model(tail, k, pc, rst_at >= 0 ? rst_at : -1);
        nuke = 1; rob_tail = 5'(tail); squash_count = 6'(k); nuke_PC = pc;
        for (int c = 1; c <= 40 && q.size() != 0; c++) begin
            @(negedge clock);
            nuke = c == intr;
            reset = c == rst_at;
            if (c == intr) begin
                rob_tail = 5'd20; squash_count = 6'd9; nuke_PC = 32'hdead;
            end
        end
        if (q.size() != 0) begin
            chk("timeout", 64'(q.size()), 0);
            q.delete();
        end
        nuke = 0; reset = 0;
    endtask

    always @(posedge clock) begin
        #1;
        if (q.size() != 0) begin
            mon_r = q.pop_front();
            chk("ctl", {flush_pipe, stall_dispatch, busy, rat_restore, redirect_valid},
                {mon_r.flush, mon_r.busy, mon_r.busy, mon_r.rat, mon_r.rv});
            chk("rd_en", walk_rd_en, mon_r.rd);
            chk("idx", walk_idx, mon_r.idx);
            chk("free_valid", free_valid, mon_r.fv);
            chk("free_PRN", free_PRN, mon_r.prn);
            if (mon_r.cpc) chk("redirect_PC", redirect_PC, mon_r.pc);
        end
    end

    initial begin
        rec_t z;
        reset = 1; nuke = 0; nuke_PC = 0; rob_tail = 0; squash_count = 0;
        for (int i = 0; i < ROB; i++) begin
            rob_prn[i] = 6'(i + 5);
            rob_rw[i] = 1'b1;
        end
        repeat (2) @(negedge clock);
        z = '0; z.cpc = 1; q.push_back(z);
        @(negedge clock);
        reset = 0;
        run(3, 5, 32'h1234, -1, -1);
        run(3, 5, 32'h1234, -1, -1);
`ifdef RECOVERY_STATS_EN
        chk("recovery_count", 64'(recovery_count), 2);
        chk("recovery_cycles", 64'(recovery_cycles), 12);
`endif
        run(7, 0, 32'h100, -1, -1);
        rob_prn[9] = 6'd10; rob_rw[9] = 1;
        rob_prn[8] = 6'd11; rob_rw[8] = 0;
        rob_prn[7] = 6'd12; rob_rw[7] = 0;
        rob_prn[6] = 6'd13; rob_rw[6] = 1;
        run(10, 4, 32'h2000, -1, -1);
        run(1, 6, 32'h3000, 2, -1);
        run(0, 31, 32'h4000, -1, -1);
        run(5, 8, 32'h5000, -1, 3);
        run(12, 3, 32'h6000, -1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob_recovery_ctrl.md
Name: rob_recovery_ctrl

Overview:
Sequences branch-mispredict recovery around the reorder buffer.
- On a nuke from ROB commit, it stalls dispatch and flushes the front end.
- It walks squashed ROB entries youngest-first, WAYS per cycle, and returns their dest PRNs to the free list.
- It then triggers the RAT restore from the architectural map and issues the fetch redirect.
- It sits between the ROB, free list, map table and fetch.

Parameters:
WAYS, 2, superscalar width; walk entries per cycle
ROB, 32, ROB entries; power of two
PRF, 64, physical registers
XLEN, 32, PC width

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
nuke  in  1  mispredicted branch committing this cycle
nuke_PC  in  XLEN  correct target PC of that branch
rob_tail  in  $clog2(ROB)  ROB tail at nuke
squash_count  in  $clog2(ROB)+1  entries younger than the branch (0..ROB-1)
walk_idx  out  WAYS x $clog2(ROB)  ROB read indices
walk_rd_en  out  WAYS  read enables
walk_PRN  in  WAYS x $clog2(PRF)  ROB dest_PRN at walk_idx, same cycle (combinational read)
walk_reg_write  in  WAYS  ROB reg_write at walk_idx, same cycle
free_PRN  out  WAYS x $clog2(PRF)  PRNs returned to free list
free_valid  out  WAYS  per-way free strobe
flush_pipe  out  1  one-cycle front-end and RS flush pulse
stall_dispatch  out  1  block dispatch
rat_restore  out  1  one-cycle pulse: copy arch map into RAT
redirect_valid  out  1  one-cycle fetch redirect
redirect_PC  out  XLEN  redirect target
busy  out  1  recovery in progress

Behaviour:
- FSM states: IDLE, FLUSH, WALK, RESTORE, REDIRECT. Reset forces IDLE at any time, including mid-walk.
- Reset values: all outputs 0; internal counters 0.
- IDLE: on nuke, latch rob_tail -> ptr, squash_count -> remaining, nuke_PC; next state FLUSH. All outputs 0.
- FLUSH (1 cycle): flush_pipe=1. Next state is WALK if remaining!=0, else RESTORE.
- WALK: n = min(WAYS, remaining).
  - For i<n: walk_rd_en[i]=1 and walk_idx[i]=(ptr-1-i) mod ROB, wrapping by truncation.
  - free_valid[i] = walk_rd_en[i] & walk_reg_write[i]; free_PRN[i] = walk_PRN[i], combinational the same cycle.
  - Lanes i>=n: walk_rd_en[i]=0, walk_idx[i]=0, free_valid[i]=0, free_PRN[i]=0.
  - Each cycle: ptr-=n, remaining-=n. When remaining-n==0, next state is RESTORE.
- RESTORE (1 cycle): rat_restore=1.
- REDIRECT (1 cycle): redirect_valid=1 and redirect_PC=latched PC; next state IDLE.
- busy=1 and stall_dispatch=1 in every state except IDLE.
- Total latency for squash_count k: 3 + ceil(k/WAYS) cycles from nuke to return to IDLE.
- nuke while not IDLE is ignored; the ROB cannot generate it because dispatch is stalled.
- The walk never touches the branch entry itself: k counts only younger entries.
- k=ROB-1 is the maximum and still wraps correctly.
- redirect_PC holds its last value outside REDIRECT; only redirect_valid qualifies it.

Optional Feature:
RECOVERY_STATS_EN:
- Defined: adds outputs recovery_count (32 bits) and recovery_cycles (32 bits).
  - recovery_count increments once per accepted nuke.
  - recovery_cycles increments every cycle busy=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - WAYS, ROB, PRF and XLEN constants.
  - The recovery_state_t enum.
  - The rob_idx_t and prn_t typedefs, shared with the ROB and free list.
- One natural sub-module: rob_walk_lane_gen, combinational. From ptr and remaining it produces walk_idx, walk_rd_en and n.
- The FSM and counters stay in rob_recovery_ctrl.

Test Plan:
- Wrap walk (WAYS=2): tail=3, k=5, all reg_write=1.
  - Walk cycle 1: idx 2,1. Cycle 2: idx 0,31. Cycle 3: idx 30 only, lane1 disabled.
  - Then rat_restore, then redirect; busy for 6 cycles.
- Zero squash: nuke with k=0, nuke_PC=0x100.
  - flush_pipe at t+1, rat_restore at t+2, redirect_valid with PC 0x100 at t+3.
  - No walk_rd_en ever asserted.
- Mixed reg_write: k=4 with reg_write pattern 1,0,0,1 and PRNs 10,11,12,13.
  - free_valid pulses only for PRN 10 and 13.
- Nuke while busy: second nuke asserted during WALK.
  - Ignored; remaining walk and redirect PC unchanged.
- Reset mid-walk: reset asserted in 2nd WALK cycle.
  - Next cycle all outputs 0 and state IDLE; a fresh nuke afterwards recovers normally.
- RECOVERY_STATS_EN defined: run the wrap-walk scenario twice.
  - recovery_count=2, recovery_cycles=12.
